// File: rtl/i2s_master_transmit.sv
// I2S master transmitter: divides clk into sck/ws and shifts stereo samples out MSB first.
// A pair accepted in frame N is sent in frame N+1; in_ready stays low while the holding buffer is full.
module i2s_master_transmit #(
  parameter int DATA_WIDTH   = 32,
  parameter int SLOT_WIDTH   = 32,
  parameter int SCK_HALF_DIV = 8,
  parameter int JUSTIFY      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun
);

  localparam int DW = $clog2(SCK_HALF_DIV);
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam logic [DW-1:0]         DIV_MAX  = DW'(SCK_HALF_DIV - 1);
  localparam logic [BW-1:0]         BCNT_MAX = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0]         SLOT     = BW'(SLOT_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  logic [DW-1:0]         div_q;
  logic                  sck_q;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  sd_q, sd_d;
  logic                  ws_q, ws_d;
  logic                  underrun_q;
  logic                  full_q, full_d;
  logic                  in_ready_q;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

  logic                  wrap, fall_tick, frame_start, accept;
  logic                  ch_d;
  logic [BW-1:0]         pos_d, bnext_d;
  logic [DATA_WIDTH-1:0] sel_d, mask_d;

  always_comb begin
    wrap        = (div_q == DIV_MAX);
    fall_tick   = wrap & sck_q;
    frame_start = fall_tick & (bcnt_q == BCNT_MAX);
    accept      = in_valid & in_ready_q;

    bcnt_d = bcnt_q;
    if (fall_tick) begin
      bcnt_d = frame_start ? '0 : bcnt_q + BW'(1);
    end

    hold_l_d = accept ? in_left  : hold_l_q;
    hold_r_d = accept ? in_right : hold_r_q;

    // An empty buffer at frame start sends silence rather than repeating the old pair.
    act_l_d = act_l_q;
    act_r_d = act_r_q;
    full_d  = full_q;
    if (frame_start) begin
      act_l_d = full_q ? hold_l_q : '0;
      act_r_d = full_q ? hold_r_q : '0;
      full_d  = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
    end

    ch_d    = (bcnt_d >= SLOT);
    pos_d   = ch_d ? bcnt_d - SLOT : bcnt_d;
    sel_d   = ch_d ? act_r_d : act_l_d;
    // Mask shifts out to zero past the sample width, giving the slot padding.
    mask_d  = MSB_ONE >> pos_d;
    sd_d    = |(sel_d & mask_d);

    bnext_d = (bcnt_d == BCNT_MAX) ? '0 : bcnt_d + BW'(1);
    if (JUSTIFY != 0) begin
      ws_d = ch_d;
    end else begin
      ws_d = (bnext_d >= SLOT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      sck_q      <= 1'b0;
      bcnt_q     <= '0;
      sd_q       <= 1'b0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b1;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
    end else begin
      div_q      <= wrap ? '0 : div_q + DW'(1);
      if (wrap) begin
        sck_q <= ~sck_q;
      end
      if (fall_tick) begin
        sd_q <= sd_d;
        ws_q <= ws_d;
      end
      bcnt_q     <= bcnt_d;
      underrun_q <= frame_start & ~full_q;
      full_q     <= full_d;
      in_ready_q <= ~full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
    end
  end

  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;
  assign in_ready = in_ready_q;

endmodule

// File: doc/i2s_master_transmit.md
# i2s_master_transmit

Parametrised I2S master transmitter. It generates `sck` and `ws` from the system clock and serialises stereo samples onto `sd`. Samples arrive through a one-deep valid/ready holding buffer. The block supports sample widths smaller than the slot width, and both Philips-I2S and left-justified framing. It sits between the audio sample source (test-tone or DSP path) and the DAC/codec pins, and replaces the fixed 32-bit slave-clocked transmitter.

## Interface
- `DATA_WIDTH`, 32: sample bits per channel.
- `SLOT_WIDTH`, 32: `sck` cycles per channel slot. Must be ≥ `DATA_WIDTH`.
- `SCK_HALF_DIV`, 8: `clk` cycles per `sck` half-period. Must be ≥ 2.
- `JUSTIFY`, 0: framing mode. 0 = Philips I2S (`ws` leads data by one `sck`); 1 = left-justified.

- `clk`  in  1  system clock; all logic runs on it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample pair offered.
- `in_ready`  out  1  holding buffer empty; a pair is accepted when `in_valid & in_ready` at a rising `clk` edge.
- `in_left`  in  DATA_WIDTH  left sample, two's complement.
- `in_right`  in  DATA_WIDTH  right sample, two's complement.
- `sck`  out  1  serial bit clock, registered.
- `ws`  out  1  word select: 0 = left, 1 = right. Registered.
- `sd`  out  1  serial data, MSB first. Registered.
- `underrun`  out  1  one-`clk` pulse when a frame starts with the holding buffer empty.

## Operation
**Divider**
- `div` counts 0..SCK_HALF_DIV-1 and wraps.
- At wrap, `sck` toggles.
- A wrap with `sck`=1 is a *fall tick*; a wrap with `sck`=0 is a *rise tick*.

**Bit counter**
- `bcnt` counts 0..2*SLOT_WIDTH-1 and advances only on fall ticks, wrapping to 0.
- Slot position `p` = `bcnt` mod SLOT_WIDTH.
- Channel `ch` = 1 when `bcnt` ≥ SLOT_WIDTH.

**Outputs** (updated on the fall tick, from the new `bcnt`)
- `sd` = active sample of channel `ch`, bit [DATA_WIDTH-1-p], when `p` < DATA_WIDTH; otherwise 0 (zero padding).
- `ws`:
  - JUSTIFY=1: `ws` = `ch`.
  - JUSTIFY=0: `ws` = channel of (`bcnt`+1) mod 2*SLOT_WIDTH, so `ws` changes one `sck` before the MSB.

**Buffering**
- Two registers: holding (left/right plus a full flag) and active (left/right).
- `in_ready` = !full, registered.
- Accepting a pair sets full on the next edge.
- Frame start is the fall tick where `bcnt` wraps 2*SLOT_WIDTH-1 → 0. At frame start:
  - If full: holding → active, full cleared.
  - If empty: active cleared to zero (silence), `underrun` pulses for that one `clk` cycle.
- A load and an accept cannot coincide, because `in_ready`=0 while full. `in_ready` rises the cycle after the transfer.

**Reset** (asynchronous)
- `div`=0, `bcnt`=0, `sck`=0, `sd`=0, `underrun`=0.
- `ws`=0 in both modes (JUSTIFY=0 forces 0 on reset, matching bcnt+1 < SLOT_WIDTH).
- Active = 0, full = 0, `in_ready`=1.
- Frame 0 after reset is silence and raises no `underrun`.
- Asserting reset mid-frame aborts the frame immediately; any held pair is discarded.

## Timing
- `sck` period = 2*SCK_HALF_DIV `clk` cycles. First `sck` rise occurs SCK_HALF_DIV cycles after reset release.
- `sd` and `ws` change only in the same `clk` cycle as the `sck` falling edge, so they are stable for a full `sck` high phase. The receiver samples on the `sck` rise.
- Frame length = 2*SLOT_WIDTH `sck` periods = 4*SLOT_WIDTH*SCK_HALF_DIV `clk` cycles.
- Latency: a pair accepted during frame N is transmitted in frame N+1. Its left MSB appears on `sd` at the frame-start fall tick.
- Throughput: at most one pair per frame. A new pair may be accepted at any time after the frame-start transfer.
- `underrun` is asserted only in the frame-start `clk` cycle.

## Test plan
- **Reset check.** DATA_WIDTH=32, SLOT_WIDTH=32, SCK_HALF_DIV=8, JUSTIFY=0. Hold `rst_n`=0 → `sck`=`ws`=`sd`=`underrun`=0, `in_ready`=1. Release → first `sck` rise after 8 clks; frame 0 `sd` is all zero; no `underrun`.
- **Philips I2S framing.** Send L=0xA5A5_F00F, R=0x1234_5678 → decoding bits on `sck` rises yields L in the `ws`=0 slot and R in the `ws`=1 slot. `ws` falls one `sck` before L's MSB.
- **Left-justified framing.** JUSTIFY=1, same data → `ws` edges coincide with the MSB bit period. Decoded values are identical.
- **Narrow samples.** DATA_WIDTH=24, SLOT_WIDTH=32, L=0x80_0001 → slot carries 1, 22×0, 1, then 8 padding zeros. `ws` period = 64 `sck`.
- **Underrun.** Supply one pair, then hold `in_valid`=0 → `underrun` pulses exactly one `clk` at the next frame start; that frame's `sd` is all zero. Resume with 100 random pairs, each offered as soon as `in_ready`=1 → 100/100 frames decode correctly with no `underrun`.
- **Mid-frame reset.** Assert `rst_n`=0 at `bcnt`=17 with a pair held → outputs go to reset values asynchronously, `in_ready`=1, and the held pair is never transmitted.
